// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - execute stage: operand forwarding, ALU, condition codes, optional MUL
// Define EXEC_MUL_EN to build the shift-add multiplier; otherwise MUL is a NOP and busy is 0.
module execute_stage #(
   parameter int DATA_WIDTH  = 16,
   parameter int SHAMT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [3:0]            alu_op,
   input  logic                  set_flags,
   input  logic                  use_imm,
   input  logic [1:0]            fwd_sel_1,
   input  logic [1:0]            fwd_sel_2,
   input  logic [DATA_WIDTH-1:0] src_1_value,
   input  logic [DATA_WIDTH-1:0] src_2_value,
   input  logic [DATA_WIDTH-1:0] imm_value,
   input  logic [DATA_WIDTH-1:0] em_result,
   input  logic [DATA_WIDTH-1:0] mw_result,
   input  logic                  flags_save,
   input  logic                  flags_restore,
   output logic [DATA_WIDTH-1:0] alu_result,
   output logic [2:0]            flags,
   output logic                  busy
);
   localparam logic [3:0] OP_MOV  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_NOT  = 4'd6;
   localparam logic [3:0] OP_INC  = 4'd7;
   localparam logic [3:0] OP_DEC  = 4'd8;
   localparam logic [3:0] OP_SHL  = 4'd9;
   localparam logic [3:0] OP_SHR  = 4'd10;
   localparam logic [3:0] OP_SETC = 4'd11;
   localparam logic [3:0] OP_CLRC = 4'd12;

   logic [DATA_WIDTH-1:0]  op_a;
   logic [DATA_WIDTH-1:0]  op_b;
   logic [DATA_WIDTH-1:0]  res;
   logic [DATA_WIDTH:0]    ext;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   c_new;
   logic                   c_upd;
   logic                   zn_upd;
   logic [2:0]             calc_flags;
   logic [2:0]             ccr_next;
   logic                   ccr_we;
   logic [2:0]             saved_flags;

   always_comb begin
      case (fwd_sel_1)
         2'd1:    op_a = em_result;
         2'd2:    op_a = mw_result;
         default: op_a = src_1_value;
      endcase
      if (use_imm) begin
         op_b = imm_value;
      end else begin
         case (fwd_sel_2)
            2'd1:    op_b = em_result;
            2'd2:    op_b = mw_result;
            default: op_b = src_2_value;
         endcase
      end
   end

   // ext carries the extra bit for carry-out and for the last bit shifted out
   always_comb begin
      shamt  = op_b[SHAMT_WIDTH-1:0];
      ext    = '0;
      res    = '0;
      c_new  = flags[2];
      c_upd  = 1'b0;
      zn_upd = 1'b0;
      case (alu_op)
         OP_MOV: begin res = op_b; zn_upd = 1'b1; end
         OP_ADD: begin
            ext    = {1'b0, op_a} + {1'b0, op_b};
            res    = ext[DATA_WIDTH-1:0];
            c_new  = ext[DATA_WIDTH];
            c_upd  = 1'b1;
            zn_upd = 1'b1;
         end
         OP_SUB: begin
            res    = op_a - op_b;
            c_new  = (op_a < op_b);
            c_upd  = 1'b1;
            zn_upd = 1'b1;
         end
         OP_AND: begin res = op_a & op_b; zn_upd = 1'b1; end
         OP_OR:  begin res = op_a | op_b; zn_upd = 1'b1; end
         OP_NOT: begin res = ~op_a;       zn_upd = 1'b1; end
         OP_INC: begin
            ext    = {1'b0, op_a} + (DATA_WIDTH+1)'(1);
            res    = ext[DATA_WIDTH-1:0];
            c_new  = ext[DATA_WIDTH];
            c_upd  = 1'b1;
            zn_upd = 1'b1;
         end
         OP_DEC: begin
            res    = op_a - DATA_WIDTH'(1);
            c_new  = (op_a == '0);
            c_upd  = 1'b1;
            zn_upd = 1'b1;
         end
         OP_SHL: begin
            ext    = {1'b0, op_a} << shamt;
            res    = ext[DATA_WIDTH-1:0];
            zn_upd = 1'b1;
            if (shamt != '0) begin
               c_new = ext[DATA_WIDTH];
               c_upd = 1'b1;
            end
         end
         OP_SHR: begin
            ext    = {op_a, 1'b0} >> shamt;
            res    = ext[DATA_WIDTH:1];
            zn_upd = 1'b1;
            if (shamt != '0) begin
               c_new = ext[0];
               c_upd = 1'b1;
            end
         end
         OP_SETC: begin c_new = 1'b1; c_upd = 1'b1; end
         OP_CLRC: begin c_new = 1'b0; c_upd = 1'b1; end
         default: ;
      endcase
      calc_flags = {c_new,
                    zn_upd ? res[DATA_WIDTH-1] : flags[1],
                    zn_upd ? (res == '0)       : flags[0]};
   end

`ifdef EXEC_MUL_EN
   localparam logic [3:0] OP_MUL   = 4'd13;
   localparam int         CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
   mul_state_t            state;
   mul_state_t            next_state;
   logic [DATA_WIDTH-1:0] mul_a;
   logic [DATA_WIDTH-1:0] mul_b;
   logic [DATA_WIDTH-1:0] acc;
   logic [CNT_W-1:0]      cnt;
   logic                  mul_start;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         acc   <= '0;
         mul_a <= '0;
         mul_b <= '0;
      end else begin
         state <= next_state;
         if (mul_start) begin
            mul_a <= op_a;
            mul_b <= op_b;
            acc   <= '0;
            cnt   <= '0;
         end else if (state == RUN) begin
            if (mul_b[cnt]) acc <= acc + (mul_a << cnt);
            cnt <= cnt + CNT_W'(1);
         end
      end
   end
`endif

   always_comb begin
      alu_result = '0;
      ccr_we     = 1'b0;
      ccr_next   = calc_flags;
      busy       = 1'b0;
`ifdef EXEC_MUL_EN
      next_state = state;
      mul_start  = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               if (alu_op == OP_MUL) begin
                  busy       = 1'b1;
                  mul_start  = 1'b1;
                  next_state = RUN;
               end else begin
                  alu_result = res;
                  ccr_we     = set_flags && (c_upd || zn_upd);
               end
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_LAST) next_state = DONE;
         end
         DONE: begin
            alu_result = acc;
            ccr_we     = set_flags;
            ccr_next   = {flags[2], acc[DATA_WIDTH-1], (acc == '0)};
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
`else
      if (en) begin
         alu_result = res;
         ccr_we     = set_flags && (c_upd || zn_upd);
      end
`endif
   end

   // Nonblocking reads give save the pre-edge CCR, so save+restore swaps
   always_ff @(posedge clk) begin
      if (reset) begin
         flags       <= '0;
         saved_flags <= '0;
      end else begin
         if (flags_save) saved_flags <= flags;
         if (flags_restore) flags <= saved_flags;
         else if (ccr_we)   flags <= ccr_next;
      end
   end
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic [3:0]  alu_op;
   logic        set_flags;
   logic        use_imm;
   logic [1:0]  fwd_sel_1;
   logic [1:0]  fwd_sel_2;
   logic [15:0] src_1_value;
   logic [15:0] src_2_value;
   logic [15:0] imm_value;
   logic [15:0] em_result;
   logic [15:0] mw_result;
   logic        flags_save;
   logic        flags_restore;
   logic [15:0] alu_result;
   logic [2:0]  flags;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   execute_stage dut (
      .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .set_flags(set_flags),
      .use_imm(use_imm), .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2),
      .src_1_value(src_1_value), .src_2_value(src_2_value), .imm_value(imm_value),
      .em_result(em_result), .mw_result(mw_result), .flags_save(flags_save),
      .flags_restore(flags_restore), .alu_result(alu_result), .flags(flags), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      alu_op      = op;
      src_1_value = a;
      src_2_value = b;
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; en = 1'b0; alu_op = 4'd0; set_flags = 1'b0; use_imm = 1'b0;
      fwd_sel_1 = 2'd0; fwd_sel_2 = 2'd0; src_1_value = '0; src_2_value = '0;
      imm_value = '0; em_result = '0; mw_result = '0; flags_save = 1'b0; flags_restore = 1'b0;
      tick(); tick();
      reset = 1'b0; #1;
      check("reset_flags", flags, 3'b000);
      check("reset_busy", busy, 1'b0);
      check("reset_result", alu_result, 16'h0000);

      en = 1'b1; set_flags = 1'b1;
      drive(4'd2, 16'hFFFF, 16'h0001); check("add_res", alu_result, 16'h0000);
      tick(); check("add_flags", flags, 3'b101);
      drive(4'd3, 16'h0003, 16'h0005); check("sub_res", alu_result, 16'hFFFE);
      tick(); check("sub_flags", flags, 3'b110);

      fwd_sel_1 = 2'd1; fwd_sel_2 = 2'd2; em_result = 16'h0010; mw_result = 16'h0020;
      drive(4'd2, 16'h5555, 16'hAAAA); check("fwd_add", alu_result, 16'h0030);
      tick(); check("fwd_flags", flags, 3'b000);
      use_imm = 1'b1; imm_value = 16'h0100; #1;
      check("imm_add", alu_result, 16'h0110);
      tick();
      use_imm = 1'b0; fwd_sel_1 = 2'd0; fwd_sel_2 = 2'd0;

      en = 1'b0;
      drive(4'd3, 16'h0003, 16'h0005); check("bubble_res", alu_result, 16'h0000);
      tick(); check("bubble_flags", flags, 3'b000);
      en = 1'b1;

      drive(4'd11, 16'h1234, 16'h0000); check("setc_res", alu_result, 16'h0000);
      tick(); check("setc_flags", flags, 3'b100);
      drive(4'd12, 16'h0000, 16'h0000); tick(); check("clrc_flags", flags, 3'b000);
      drive(4'd9, 16'h8001, 16'h0001); check("shl_res", alu_result, 16'h0002);
      tick(); check("shl_flags", flags, 3'b100);
      drive(4'd10, 16'h0001, 16'h0010); check("shr0_res", alu_result, 16'h0001);
      tick(); check("shr0_flags", flags, 3'b100);
      drive(4'd10, 16'h0002, 16'h0001); check("shr1_res", alu_result, 16'h0001);
      tick(); check("shr1_flags", flags, 3'b000);
      drive(4'd8, 16'h0000, 16'h0000); check("dec_res", alu_result, 16'hFFFF);
      tick(); check("dec_flags", flags, 3'b110);
      drive(4'd7, 16'hFFFF, 16'h0000); check("inc_res", alu_result, 16'h0000);
      tick(); check("inc_flags", flags, 3'b101);

      set_flags = 1'b0;
      drive(4'd4, 16'hF0F0, 16'h0FF0); check("and_res", alu_result, 16'h00F0); tick();
      drive(4'd5, 16'hF000, 16'h000F); check("or_res", alu_result, 16'hF00F); tick();
      drive(4'd6, 16'h00FF, 16'h0000); check("not_res", alu_result, 16'hFF00); tick();
      use_imm = 1'b1; imm_value = 16'h1234;
      drive(4'd1, 16'h0000, 16'h0000); check("mov_imm_res", alu_result, 16'h1234); tick();
      use_imm = 1'b0;
      check("noflag_ops", flags, 3'b101);

      set_flags = 1'b1;
      drive(4'd0, 16'h1234, 16'h0001); check("nop_res", alu_result, 16'h0000); tick();
      drive(4'd14, 16'h1234, 16'h0001); check("op14_res", alu_result, 16'h0000); tick();
      check("nop_flags", flags, 3'b101);

`ifdef EXEC_MUL_EN
      drive(4'd13, 16'h0012, 16'h0034);
      check("mul_issue_busy", busy, 1'b1);
      check("mul_issue_res", alu_result, 16'h0000);
      n = 1;
      while (busy === 1'b1 && n < 40) begin tick(); n++; end
      check("mul_len", n, 18);
      check("mul_res", alu_result, 16'h03A8);
      tick(); drive(4'd0, 16'h0000, 16'h0000);
      check("mul_flags", flags, 3'b100);
      check("mul_no_restart", busy, 1'b0);

      drive(4'd13, 16'h8000, 16'h0002);
      n = 1;
      while (busy === 1'b1 && n < 40) begin tick(); n++; end
      check("mul2_len", n, 18);
      check("mul2_res", alu_result, 16'h0000);
      tick(); drive(4'd0, 16'h0000, 16'h0000);
      check("mul2_flags", flags, 3'b101);
`else
      drive(4'd13, 16'h0012, 16'h0034);
      check("mul_off_busy", busy, 1'b0);
      check("mul_off_res", alu_result, 16'h0000);
      tick(); check("mul_off_flags", flags, 3'b101);
`endif

      drive(4'd13, 16'h0012, 16'h0034);
      for (int i = 0; i < 6; i++) tick();
`ifdef EXEC_MUL_EN
      check("mid_mul_busy", busy, 1'b1);
`endif
      reset = 1'b1; tick(); tick();
      reset = 1'b0;
      drive(4'd0, 16'h0000, 16'h0000);
      check("rst_mul_busy", busy, 1'b0);
      check("rst_mul_flags", flags, 3'b000);
      check("rst_mul_res", alu_result, 16'h0000);
`ifdef EXEC_MUL_EN
      drive(4'd13, 16'h0003, 16'h0005);
      n = 1;
      while (busy === 1'b1 && n < 40) begin tick(); n++; end
      check("mul3_len", n, 18);
      check("mul3_res", alu_result, 16'h000F);
      tick(); drive(4'd0, 16'h0000, 16'h0000);
`endif

      drive(4'd7, 16'hFFFF, 16'h0000); tick();
      check("sr_setup", flags, 3'b101);
      en = 1'b0; flags_save = 1'b1; tick(); flags_save = 1'b0; en = 1'b1;
      drive(4'd12, 16'h0000, 16'h0000); tick();
      check("sr_clrc", flags, 3'b001);
      flags_restore = 1'b1;
      drive(4'd2, 16'h0001, 16'h0001); tick();
      flags_restore = 1'b0;
      check("sr_restore_wins", flags, 3'b101);
      drive(4'd3, 16'h0003, 16'h0005); tick();
      check("sr_sub", flags, 3'b110);
      en = 1'b0; flags_save = 1'b1; flags_restore = 1'b1; tick();
      flags_save = 1'b0;
      check("swap_ccr", flags, 3'b101);
      tick();
      flags_restore = 1'b0;
      check("swap_saved", flags, 3'b110);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
